// File: rtl/multi_alarm_rtc.sv
// Real-time clock with N alarm channels, key-driven time/alarm editing and a timed ring output.
// Time advances on a 1 s prescaler tick that only runs in RUN; all editing happens in the SET states.
module multi_alarm_rtc #(
    parameter int CLK_FREQ = 12000000,
    parameter int N_ALARM  = 4,
    parameter int RING_SEC = 10,
    localparam int AW = (N_ALARM > 1) ? $clog2(N_ALARM) : 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               key_mode,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               set_alarm,
    input  logic [AW-1:0]      alm_sel,
    input  logic [N_ALARM-1:0] alm_en,
    input  logic               ring_stop,
    output logic [4:0]         hour,
    output logic [5:0]         min,
    output logic [5:0]         sec,
    output logic [1:0]         mode,
    output logic               tick_1s,
    output logic               ring,
    output logic [AW-1:0]      ring_ch
);
    // state | meaning
    // RUN   | clock running, only key_mode acts
    // SET_H | edit hour of the latched target
    // SET_M | edit minute of the latched target
    // SET_S | edit seconds (time target only)
    localparam logic [1:0] RUN   = 2'd0;
    localparam logic [1:0] SET_H = 2'd1;
    localparam logic [1:0] SET_M = 2'd2;
    localparam logic [1:0] SET_S = 2'd3;

    localparam int             PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_FREQ - 1);

    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          tgt_alarm_q, tgt_alarm_d;
    logic [AW-1:0] tgt_ch_q, tgt_ch_d;
    logic [4:0]    alm_hour_q [N_ALARM];
    logic [4:0]    alm_hour_d [N_ALARM];
    logic [5:0]    alm_min_q  [N_ALARM];
    logic [5:0]    alm_min_d  [N_ALARM];
    logic          ring_q, ring_d;
    logic [AW-1:0] ring_ch_q, ring_ch_d;
    logic [7:0]    ring_cnt_q, ring_cnt_d;

    logic          tick;
    logic [4:0]    nxt_h;
    logic [5:0]    nxt_m;
    logic [5:0]    nxt_s;
    logic          match;
    logic [AW-1:0] match_ch;

    function automatic logic [5:0] step_wrap(input logic [5:0] v, input logic [5:0] top,
                                             input logic up);
        logic [5:0] r;
        if (up) r = (v >= top) ? 6'd0 : v + 6'd1;
        else    r = (v == 6'd0 || v > top) ? top : v - 6'd1;
        return r;
    endfunction

    assign tick = (mode_q == RUN) && (presc_q == PRESC_MAX);

    always_comb begin
        mode_d      = mode_q;
        presc_d     = presc_q;
        tgt_alarm_d = tgt_alarm_q;
        tgt_ch_d    = tgt_ch_q;
        alm_hour_d  = alm_hour_q;
        alm_min_d   = alm_min_q;
        ring_d      = ring_q;
        ring_ch_d   = ring_ch_q;
        ring_cnt_d  = ring_cnt_q;
        match       = 1'b0;
        match_ch    = '0;

        nxt_h = hour_q;
        nxt_m = min_q;
        nxt_s = sec_q;
        if (tick) begin
            if (sec_q == 6'd59) begin
                nxt_s = 6'd0;
                if (min_q == 6'd59) begin
                    nxt_m = 6'd0;
                    nxt_h = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    nxt_m = min_q + 6'd1;
                end
            end else begin
                nxt_s = sec_q + 6'd1;
            end
        end
        hour_d = nxt_h;
        min_d  = nxt_m;
        sec_d  = nxt_s;

        if (key_mode) begin
            case (mode_q)
                RUN: begin
                    mode_d      = SET_H;
                    tgt_alarm_d = set_alarm;
                    tgt_ch_d    = alm_sel;
                    if (!set_alarm) sec_d = 6'd0;
                end
                SET_H:   mode_d = SET_M;
                SET_M:   mode_d = tgt_alarm_q ? RUN : SET_S;
                default: mode_d = RUN;
            endcase
        end else if (key_up || key_down) begin
            case (mode_q)
                SET_H: begin
                    if (!tgt_alarm_q) hour_d = 5'(step_wrap({1'b0, hour_q}, 6'd23, key_up));
                    for (int k = 0; k < N_ALARM; k++)
                        if (tgt_alarm_q && tgt_ch_q == AW'(k))
                            alm_hour_d[k] = 5'(step_wrap({1'b0, alm_hour_q[k]}, 6'd23, key_up));
                end
                SET_M: begin
                    if (!tgt_alarm_q) min_d = step_wrap(min_q, 6'd59, key_up);
                    for (int k = 0; k < N_ALARM; k++)
                        if (tgt_alarm_q && tgt_ch_q == AW'(k))
                            alm_min_d[k] = step_wrap(alm_min_q[k], 6'd59, key_up);
                end
                SET_S: begin
                    if (!tgt_alarm_q) sec_d = step_wrap(sec_q, 6'd59, key_up);
                end
                default: ;
            endcase
        end

        // Held at zero through SET and on the return edge so the first tick is a full second away.
        if (mode_q != RUN || mode_d != RUN) presc_d = '0;
        else if (tick)                      presc_d = '0;
        else                                presc_d = presc_q + PW'(1);

        for (int k = N_ALARM - 1; k >= 0; k--) begin
            if (tick && alm_en[k] && nxt_s == 6'd0 &&
                nxt_h == alm_hour_q[k] && nxt_m == alm_min_q[k]) begin
                match    = 1'b1;
                match_ch = AW'(k);
            end
        end

        if (ring_stop) begin
            ring_d = 1'b0;
        end else if (ring_q) begin
            if (ring_cnt_q == 8'd0) ring_d = 1'b0;
            else if (tick)          ring_cnt_d = ring_cnt_q - 8'd1;
        end else if (match) begin
            ring_d     = 1'b1;
            ring_ch_d  = match_ch;
            ring_cnt_d = 8'(RING_SEC);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_q      <= RUN;
            presc_q     <= '0;
            hour_q      <= 5'd0;
            min_q       <= 6'd0;
            sec_q       <= 6'd0;
            tgt_alarm_q <= 1'b0;
            tgt_ch_q    <= '0;
            ring_q      <= 1'b0;
            ring_ch_q   <= '0;
            ring_cnt_q  <= 8'd0;
            for (int k = 0; k < N_ALARM; k++) begin
                alm_hour_q[k] <= 5'd0;
                alm_min_q[k]  <= 6'd5;
            end
        end else begin
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            hour_q      <= hour_d;
            min_q       <= min_d;
            sec_q       <= sec_d;
            tgt_alarm_q <= tgt_alarm_d;
            tgt_ch_q    <= tgt_ch_d;
            ring_q      <= ring_d;
            ring_ch_q   <= ring_ch_d;
            ring_cnt_q  <= ring_cnt_d;
            alm_hour_q  <= alm_hour_d;
            alm_min_q   <= alm_min_d;
        end
    end

    assign hour    = hour_q;
    assign min     = min_q;
    assign sec     = sec_q;
    assign mode    = mode_q;
    assign tick_1s = tick;
    assign ring    = ring_q;
    assign ring_ch = ring_ch_q;

endmodule
